// File: rtl/sdram_arb_pkg.sv
// Shared constants, FSM encoding and helpers for the two-requester SDRAM arbiter.
package sdram_arb_pkg;

    localparam int NUM_REQ    = 2;
    localparam int ADDR_W_DEF = 23;
    localparam int DATA_W_DEF = 32;
    localparam int WAIT_CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT_RD = 2'd2
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] req_onehot(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/sdram_rr_arbiter.sv
// Two-way round-robin grant selection; the pointer remembers who won last.
module sdram_rr_arbiter
    import sdram_arb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               advance,
    output logic [NUM_REQ-1:0] grant
);

    logic last_q, last_d;

    always_comb begin
        grant = req;
        if (req[0] && req[1]) begin
            grant = last_q ? 2'b01 : 2'b10;
        end
    end

    always_comb begin
        last_d = last_q;
        if (advance) begin
            last_d = grant[1];
        end
    end

    // Reset as "requester 1 won last" so requester 0 takes the first contested grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/sdram_arbiter.sv
// Arbitrates two requesters onto a single SDRAM controller port, one transaction
// in flight, with a read-data timeout that returns an error response.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0]        req_rw,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
    input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        rsp_valid,
    output logic [DATA_W-1:0]         rsp_rdata,
    output logic                      rsp_err,
    output logic [ADDR_W-1:0]         ctrl_addr,
    output logic                      ctrl_rw,
    output logic [DATA_W-1:0]         ctrl_data_in,
    output logic                      ctrl_in_valid,
    input  logic                      ctrl_busy,
    input  logic                      ctrl_out_valid,
    input  logic [DATA_W-1:0]         ctrl_data_out
);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    rr_grant;
    logic                  grant_fire, accept, rd_done, rd_tmo;
    logic                  owner_q, owner_d;
    logic                  rw_q, rw_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [WAIT_CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;

    sdram_rr_arbiter u_rr (
        .clk     (clk),
        .rst     (rst),
        .req     (req_valid),
        .advance (grant_fire),
        .grant   (rr_grant)
    );

    // A pending response blocks the grant so ready and response never share a cycle.
    always_comb begin
        grant_fire = (state_q == ST_IDLE) && (|req_valid) && !(|rsp_valid_q) && !rst;
        accept     = (state_q == ST_ISSUE) && !ctrl_busy;
        rd_done    = (state_q == ST_WAIT_RD) && ctrl_out_valid;
        rd_tmo     = (state_q == ST_WAIT_RD) && !ctrl_out_valid &&
                     (wait_cnt_q == WAIT_CNT_W'(TIMEOUT - 1));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:    if (grant_fire) state_d = ST_ISSUE;
            ST_ISSUE:   if (accept) state_d = rw_q ? ST_IDLE : ST_WAIT_RD;
            ST_WAIT_RD: if (rd_done || rd_tmo) state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        req_ready     = grant_fire ? rr_grant : '0;
        ctrl_in_valid = (state_q == ST_ISSUE);
        ctrl_addr     = addr_q;
        ctrl_rw       = rw_q;
        ctrl_data_in  = wdata_q;
        rsp_valid     = rsp_valid_q;
        rsp_err       = rsp_err_q;
        rsp_rdata     = rsp_rdata_q;
    end

    always_comb begin
        owner_d = owner_q;
        rw_d    = rw_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        if (grant_fire) begin
            owner_d = rr_grant[1];
            rw_d    = rr_grant[1] ? req_rw[1] : req_rw[0];
            addr_d  = rr_grant[1] ? req_addr[ADDR_W +: ADDR_W] : req_addr[0 +: ADDR_W];
            wdata_d = rr_grant[1] ? req_wdata[DATA_W +: DATA_W] : req_wdata[0 +: DATA_W];
        end

        // Counter only runs in WAIT_RD, so it is zero on every entry.
        wait_cnt_d = '0;
        if (state_q == ST_WAIT_RD) begin
            wait_cnt_d = wait_cnt_q + 1'b1;
        end

        rsp_valid_d = '0;
        rsp_err_d   = 1'b0;
        rsp_rdata_d = '0;
        if ((accept && rw_q) || rd_done || rd_tmo) begin
            rsp_valid_d = req_onehot(owner_q);
        end
        if (rd_done) begin
            rsp_rdata_d = ctrl_data_out;
        end
        if (rd_tmo) begin
            rsp_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= '0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            owner_q     <= owner_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed and randomized checks of sdram_arbiter against a transaction-level model.
module tb_sdram_arbiter;

    localparam int AW  = 23;
    localparam int DW  = 32;
    localparam int TMO = 8;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      req_valid, req_rw, req_ready, rsp_valid;
    logic [2*AW-1:0] req_addr;
    logic [2*DW-1:0] req_wdata;
    logic [DW-1:0]   rsp_rdata, ctrl_data_in, ctrl_data_out;
    logic            rsp_err, ctrl_rw, ctrl_in_valid, ctrl_busy, ctrl_out_valid;
    logic [AW-1:0]   ctrl_addr;

    int n_cmp = 0;
    int n_bad = 0;

    // Model: pending request per requester and who was granted most recently.
    bit            pend   [2];
    bit            p_rw   [2];
    logic [AW-1:0] p_addr [2];
    logic [DW-1:0] p_data [2];
    int            last_gnt;
    int            won;

    sdram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TMO)) dut (
        .clk            (clk),
        .rst            (rst),
        .req_valid      (req_valid),
        .req_rw         (req_rw),
        .req_addr       (req_addr),
        .req_wdata      (req_wdata),
        .req_ready      (req_ready),
        .rsp_valid      (rsp_valid),
        .rsp_rdata      (rsp_rdata),
        .rsp_err        (rsp_err),
        .ctrl_addr      (ctrl_addr),
        .ctrl_rw        (ctrl_rw),
        .ctrl_data_in   (ctrl_data_in),
        .ctrl_in_valid  (ctrl_in_valid),
        .ctrl_busy      (ctrl_busy),
        .ctrl_out_valid (ctrl_out_valid),
        .ctrl_data_out  (ctrl_data_out)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int i, input bit rw, input logic [AW-1:0] a, input logic [DW-1:0] d);
        pend[i]   = 1'b1;
        p_rw[i]   = rw;
        p_addr[i] = a;
        p_data[i] = d;
    endtask

    // Requesters that are not pending get garbage fields the arbiter must not sample.
    task automatic drive_reqs();
        for (int i = 0; i < 2; i++) begin
            req_valid[i]           = pend[i];
            req_rw[i]              = pend[i] ? p_rw[i] : 1'($urandom);
            req_addr[i*AW +: AW]   = pend[i] ? p_addr[i] : AW'($urandom);
            req_wdata[i*DW +: DW]  = pend[i] ? p_data[i] : DW'($urandom);
        end
    endtask

    task automatic new_reqs();
        for (int i = 0; i < 2; i++) begin
            if (!pend[i] && ($urandom_range(0, 1) == 1)) begin
                set_req(i, 1'($urandom), AW'($urandom), DW'($urandom));
            end
        end
        if (!pend[0] && !pend[1]) begin
            set_req(int'($urandom_range(0, 1)), 1'($urandom), AW'($urandom), DW'($urandom));
        end
    endtask

    // One full transaction starting in an IDLE cycle that is free to grant.
    // rd_d: cycles after acceptance at which ctrl_out_valid pulses (0 or > TMO: never usefully).
    task automatic do_txn(input int busy_n, input int rd_d, input logic [DW-1:0] rd_val, output int w);
        int rsp_at;
        bit exp_err;
        drive_reqs();
        ctrl_busy      = 1'b0;
        ctrl_out_valid = 1'b0;
        if (pend[0] && pend[1]) w = 1 - last_gnt;
        else                    w = pend[1] ? 1 : 0;
        @(negedge clk);
        chk("grant", req_ready, 64'(1) << w);
        chk("grant_no_rsp", rsp_valid, 0);
        tick();
        last_gnt = w;
        pend[w]  = 1'b0;
        drive_reqs();
        for (int c = 0; c <= busy_n; c++) begin
            ctrl_busy      = (c < busy_n);
            ctrl_out_valid = (rd_d == 0) && (c == busy_n);
            ctrl_data_out  = $urandom;
            @(negedge clk);
            chk("issue_in_valid", ctrl_in_valid, 1);
            chk("issue_fields", {ctrl_rw, ctrl_addr, ctrl_data_in}, {p_rw[w], p_addr[w], p_data[w]});
            chk("issue_no_ready", req_ready, 0);
            chk("issue_no_rsp", rsp_valid, 0);
            tick();
        end
        ctrl_busy = 1'($urandom);
        if (p_rw[w]) begin
            ctrl_out_valid = 1'b0;
            @(negedge clk);
            chk("wr_rsp", rsp_valid, 64'(1) << w);
            chk("wr_err_rdata", {rsp_err, rsp_rdata}, 0);
            chk("wr_in_valid", ctrl_in_valid, 0);
            chk("wr_no_ready", req_ready, 0);
            tick();
        end else begin
            exp_err = !(rd_d >= 1 && rd_d <= TMO);
            rsp_at  = exp_err ? TMO + 1 : rd_d + 1;
            for (int k = 1; k <= rsp_at; k++) begin
                ctrl_out_valid = (k == rd_d);
                ctrl_data_out  = (k == rd_d) ? rd_val : DW'($urandom);
                @(negedge clk);
                chk("rd_in_valid", ctrl_in_valid, 0);
                chk("rd_no_ready", req_ready, 0);
                chk("rd_rsp", rsp_valid, (k == rsp_at) ? (64'(1) << w) : 64'(0));
                if (k == rsp_at) begin
                    chk("rd_err", rsp_err, exp_err);
                    chk("rd_rdata", rsp_rdata, exp_err ? 64'(0) : 64'(rd_val));
                end
                tick();
            end
            ctrl_out_valid = 1'b0;
        end
    endtask

    task automatic do_reset();
        rst            = 1'b1;
        req_valid      = 2'b11;
        ctrl_busy      = 1'b0;
        ctrl_out_valid = 1'b1;
        tick();
        @(negedge clk);
        chk("rst_ready", req_ready, 0);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
        chk("rst_ctrl", {ctrl_in_valid, ctrl_rw, ctrl_addr}, 0);
        chk("rst_wdata", ctrl_data_in, 0);
        tick();
        rst            = 1'b0;
        ctrl_out_valid = 1'b0;
        pend[0]        = 1'b0;
        pend[1]        = 1'b0;
        last_gnt       = 1;
        drive_reqs();
    endtask

    initial begin
        rst = 1'b1;
        ctrl_data_out = '0;
        req_rw = '0;
        req_addr = '0;
        req_wdata = '0;
        do_reset();

        // Single write
        set_req(0, 1'b1, 23'h000010, 32'hDEADBEEF);
        do_txn(0, 0, 32'h0, won);

        // Contention after reset: 0,1,0,1
        do_reset();
        for (int t = 0; t < 4; t++) begin
            for (int i = 0; i < 2; i++) begin
                if (!pend[i]) set_req(i, 1'b0, AW'($urandom), DW'($urandom));
            end
            do_txn(0, 2, $urandom, won);
            chk("rr_order", won, t % 2);
        end
        // Drain the leftover pending requester
        do_txn(0, 1, $urandom, won);

        // Read from requester 1, data 5 cycles after accept
        set_req(1, 1'b0, 23'h7FFFFF, 32'h0);
        do_txn(0, 5, 32'h12345678, won);

        // Busy stall of 10 cycles
        set_req(0, 1'b1, 23'h155555, 32'hA5A5A5A5);
        do_txn(10, 0, 32'h0, won);

        // Timeout, then late ctrl_out_valid ignored
        set_req(1, 1'b0, 23'h000123, 32'h0);
        do_txn(2, 1000, 32'h0, won);
        drive_reqs();
        for (int k = 0; k < 3; k++) begin
            ctrl_out_valid = 1'b1;
            ctrl_data_out  = $urandom;
            @(negedge clk);
            chk("late_rdv_rsp", rsp_valid, 0);
            chk("late_rdv_in_valid", ctrl_in_valid, 0);
            tick();
        end
        ctrl_out_valid = 1'b0;

        // Data and timeout in the same cycle: data wins
        set_req(0, 1'b0, 23'h0000AA, 32'h0);
        do_txn(0, TMO, 32'h0BADCAFE, won);

        // Reset pulse while waiting for read data
        set_req(0, 1'b0, 23'h00ABCD, 32'h0);
        drive_reqs();
        @(negedge clk);
        chk("r44_grant", req_ready, 1);
        tick();
        pend[0] = 1'b0;
        drive_reqs();
        ctrl_busy = 1'b0;
        @(negedge clk);
        chk("r44_issue", ctrl_in_valid, 1);
        tick();
        @(negedge clk);
        chk("r44_wait", ctrl_in_valid, 0);
        tick();
        rst            = 1'b1;
        ctrl_out_valid = 1'b1;
        ctrl_data_out  = 32'hCAFEF00D;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("r44_no_rsp", {rsp_valid, rsp_err, rsp_rdata}, 0);
            chk("r44_ctrl_zero", {ctrl_in_valid, ctrl_rw, ctrl_addr}, 0);
            chk("r44_wdata_zero", ctrl_data_in, 0);
            tick();
        end
        ctrl_out_valid = 1'b0;
        last_gnt = 1;
        set_req(0, 1'b1, 23'h000001, 32'h11111111);
        set_req(1, 1'b1, 23'h000002, 32'h22222222);
        do_txn(0, 0, 32'h0, won);
        chk("r44_first_contested", won, 0);
        do_txn(0, 0, 32'h0, won);

        // Randomized traffic
        for (int t = 0; t < 60; t++) begin
            new_reqs();
            do_txn(int'($urandom_range(0, 3)), int'($urandom_range(0, TMO + 3)), $urandom, won);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
SDRAM_ARBITER -- requirements
Module: sdram_arbiter

Interface
REQ-001 Parameter ADDR_W, 23, width of the SDRAM controller user address.
REQ-002 Parameter DATA_W, 32, data word width.
REQ-003 Parameter TIMEOUT, 64, maximum cycles to wait for read data before an error response (range 2..255).
REQ-004 Port clk  input  1  single clock; all logic SHALL be clocked on its rising edge.
REQ-005 Port rst  input  1  reset; synchronous and active-high.
REQ-006 Port req_valid  input  2  per-requester request, bit i is requester i.
REQ-007 Port req_rw  input  2  per-requester direction: 1 = write, 0 = read.
REQ-008 Port req_addr  input  2*ADDR_W  per-requester address, requester i at [i*ADDR_W +: ADDR_W].
REQ-009 Port req_wdata  input  2*DATA_W  per-requester write data, packed the same way.
REQ-010 Port req_ready  output  2  one-cycle accept pulse, one-hot or zero.
REQ-011 Port rsp_valid  output  2  one-cycle completion pulse, one-hot or zero.
REQ-012 Port rsp_rdata  output  DATA_W  read data, valid while any rsp_valid bit is high.
REQ-013 Port rsp_err  output  1  timeout flag, valid while any rsp_valid bit is high.
REQ-014 Port ctrl_addr, ctrl_rw, ctrl_data_in  output  ADDR_W/1/DATA_W  request fields driven to the SDRAM controller.
REQ-015 Port ctrl_in_valid  output  1  command strobe to the controller.
REQ-016 Port ctrl_busy, ctrl_out_valid  input  1 each  controller busy flag and read-data strobe.
REQ-017 Port ctrl_data_out  input  DATA_W  controller read data.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, ISSUE and WAIT_RD.
REQ-019 In IDLE with any req_valid bit set, the block SHALL grant one requester, pulse its req_ready, latch its rw/addr/wdata and go to ISSUE on the next cycle.
REQ-020 When both requesters are valid, grant SHALL go to the requester not granted last (round-robin); a single valid requester SHALL always be granted.
REQ-021 A requester SHALL hold req_valid and its fields stable until its req_ready pulse; the arbiter SHALL NOT sample a requester's fields except in its grant cycle.
REQ-022 In ISSUE, ctrl_in_valid SHALL be high and ctrl_addr/rw/data_in SHALL carry the latched fields; the command is accepted in the first ISSUE cycle with ctrl_busy low.
REQ-023 A write accepted in ISSUE SHALL pulse rsp_valid for the granted requester in the cycle after acceptance, with rsp_err=0 and rsp_rdata=0, and SHALL return the FSM to IDLE.
REQ-024 A read accepted in ISSUE SHALL move to WAIT_RD, with ctrl_in_valid low from the next cycle.
REQ-025 In WAIT_RD, ctrl_out_valid SHALL capture ctrl_data_out into rsp_rdata and pulse rsp_valid to the granted requester with rsp_err=0, one cycle after ctrl_out_valid; the FSM then returns to IDLE.
REQ-026 A wait counter SHALL clear on entry to WAIT_RD and increment each cycle there.
REQ-027 If the wait counter reaches TIMEOUT without ctrl_out_valid, the block SHALL pulse rsp_valid with rsp_err=1 and rsp_rdata=0 and return to IDLE.
REQ-028 If ctrl_out_valid and the timeout occur in the same cycle, data SHALL win (rsp_err=0).
REQ-029 ctrl_out_valid outside WAIT_RD SHALL be ignored.
REQ-030 Only one transaction SHALL be outstanding at a time; req_ready SHALL NOT pulse outside IDLE.
REQ-031 The round-robin pointer SHALL update only on a grant.
REQ-032 Minimum latency from req_ready to write rsp_valid SHALL be 2 cycles (grant, ISSUE with ctrl_busy low, response).
REQ-033 rsp_valid and req_ready MAY both pulse in the same cycle only if the IDLE return and the new grant coincide; the implementation SHALL instead grant no earlier than the cycle after the response.

Reset
REQ-034 While rst is high, the FSM SHALL go to IDLE and the following SHALL be 0: req_ready, rsp_valid, rsp_err, rsp_rdata, ctrl_in_valid, ctrl_rw, ctrl_addr, ctrl_data_in and the wait counter.
REQ-035 While rst is high, the round-robin pointer SHALL be set so that requester 0 wins the first contested grant.
REQ-036 Reset mid-transaction SHALL drop the transaction silently, with no rsp_valid generated.

Structure
REQ-037 The FSM state enum, requester count (2) and the default ADDR_W/DATA_W constants SHALL live in shared package sdram_arb_pkg.
REQ-038 Grant selection and pointer update SHALL be a sub-module sdram_rr_arbiter (inputs: req[1:0], advance; output: one-hot grant).

Verification
REQ-039 Single write: req0 write addr 0x000010, data 0xDEADBEEF, ctrl_busy=0 -> req_ready[0] at T, ctrl_in_valid at T+1 with those fields, rsp_valid[0] at T+2.
REQ-040 Contention: both valid reads after reset -> grant order 0,1,0,1 over four back-to-back transactions, with no double grant.
REQ-041 Read: req1 read addr 0x7FFFFF, ctrl_out_valid 5 cycles after accept with data 0x12345678 -> rsp_valid[1] with rsp_rdata=0x12345678 and rsp_err=0.
REQ-042 Busy stall: ctrl_busy held high for 10 cycles in ISSUE -> ctrl_in_valid and fields held stable for all 10 cycles, then accept on the first busy-low cycle.
REQ-043 Timeout: read accepted and ctrl_out_valid never asserted, TIMEOUT=8 -> rsp_valid with rsp_err=1; a late ctrl_out_valid afterwards is ignored.
REQ-044 Reset in WAIT_RD: rst pulsed for 1 cycle -> no rsp_valid, all outputs 0, and the next contested grant goes to requester 0.
